// File: rtl/uartrx.sv
// rtl/uartrx.sv - 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM.
module uartrx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       donerx,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int BP = clk_freq / baud_rate;
    localparam int HP = BP / 2;
    localparam int CW = (BP > 2) ? $clog2(BP) : 1;
    localparam logic [CW-1:0] BP_LAST = CW'(BP - 1);
    localparam logic [CW-1:0] HP_LAST = CW'(HP - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          rx_meta_q, rxs_q, rxs_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          donerx_q, donerx_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            donerx_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            donerx_q    <= donerx_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        donerx_d    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Edge-only start keeps a held-low break from re-triggering.
                cnt_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BP_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxs_q) begin
                        rx_data_d = shift_q;
                        donerx_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign donerx    = donerx_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_uartrx.sv
// tb/tb_uartrx.sv - randomized self-checking bench for uartrx against a frame-level model.
module tb_uartrx;
    localparam int BP = 1000000 / 9600;
    localparam int HP = BP / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       donerx, frame_err, rx_busy;

    uartrx #(.clk_freq(1000000), .baud_rate(9600)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .donerx(donerx), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0;
    int last_done_cyc = 0;
    logic prev_done = 1'b0, prev_ferr = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_rx_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts events and captures rx_data at each donerx.
    always @(negedge clk) begin
        if (!rst) begin
            if (donerx) begin
                done_cnt++;
                got_q.push_back(rx_data);
                last_done_cyc = cyc;
            end
            if (frame_err) ferr_cnt++;
            if (donerx && frame_err) both_cnt++;
            if ((donerx && prev_done) || (frame_err && prev_ferr)) wide_cnt++;
        end
        prev_done = donerx;
        prev_ferr = frame_err;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bp, input logic stop);
        send_bit(1'b0, bp);
        for (int i = 0; i < 8; i++) send_bit(b[i], bp);
        send_bit(stop, bp);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rx_data !== 8'h00 || donerx !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h done=%b ferr=%b busy=%b want 00 0 0 0",
                     rx_data, donerx, frame_err, rx_busy);
        end
        rst = 1'b0;
        idle(10);
        checks++;
        if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_idle got busy=%b data=%h want 0 00", rx_busy, rx_data);
        end
    endtask

    task automatic test_a5();
        int d0, f0, start_cyc, lat;
        d0 = done_cnt; f0 = ferr_cnt; got_q.delete();
        start_cyc = cyc;
        send_frame(8'hA5, BP, 1'b1);
        idle(20);
        exp_rx_data = 8'hA5;
        checks++;
        if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL a5_pulses got done=%0d ferr=%0d want 1 0", done_cnt - d0, ferr_cnt - f0);
        end
        checks++;
        if (rx_data !== exp_rx_data || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_data got data=%h busy=%b want %h 0", rx_data, rx_busy, exp_rx_data);
        end
        lat = last_done_cyc - start_cyc;
        checks++;
        if (lat < 1 + HP + 9 * BP || lat > 3 + HP + 9 * BP) begin
            failures++;
            $display("FAIL a5_latency got %0d want %0d +/-1", lat, 2 + HP + 9 * BP);
        end
    endtask

    task automatic test_glitch();
        int d0, f0, k;
        bit seen_busy;
        d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0, 20);
        seen_busy = rx_busy;
        rx = 1'b1;
        k = 0;
        while (rx_busy === 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!seen_busy) begin
            failures++;
            $display("FAIL glitch_busy_seen got 0 want 1");
        end
        checks++;
        if (20 + k > HP + 3 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_drop got %0d cycles busy=%b want <= %0d 0", 20 + k, rx_busy, HP + 3);
        end
        idle(BP * 10);
        checks++;
        if (done_cnt != d0 || ferr_cnt != f0 || rx_data !== exp_rx_data) begin
            failures++;
            $display("FAIL glitch_quiet got done=%0d ferr=%0d data=%h want 0 0 %h",
                     done_cnt - d0, ferr_cnt - f0, rx_data, exp_rx_data);
        end
    endtask

    task automatic test_frame_err();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, BP, 1'b0);
        send_bit(1'b0, 2000);
        checks++;
        if (ferr_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL ferr_pulses got ferr=%0d done=%0d want 1 0", ferr_cnt - f0, done_cnt - d0);
        end
        checks++;
        if (rx_data !== exp_rx_data || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_hold got data=%h busy=%b want %h 0", rx_data, rx_busy, exp_rx_data);
        end
        idle(50);
    endtask

    task automatic test_reset_midframe();
        int d0, f0;
        send_bit(1'b0, BP);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BP);
        send_bit(1'b1, 30);
        rst = 1'b1;
        #1;
        checks++;
        if (rx_data !== 8'h00 || donerx !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_rst got data=%h done=%b ferr=%b busy=%b want 00 0 0 0",
                     rx_data, donerx, frame_err, rx_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rx_data = 8'h00;
        d0 = done_cnt; f0 = ferr_cnt; got_q.delete();
        idle(BP * 6);
        send_frame(8'h5A, BP, 1'b1);
        idle(20);
        exp_rx_data = 8'h5A;
        checks++;
        if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0 || rx_data !== exp_rx_data) begin
            failures++;
            $display("FAIL after_rst_5a got done=%0d ferr=%0d data=%h want 1 0 %h",
                     done_cnt - d0, ferr_cnt - f0, rx_data, exp_rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt; got_q.delete();
        send_frame(8'h00, BP, 1'b1);
        send_frame(8'hFF, BP, 1'b1);
        idle(20);
        exp_rx_data = 8'hFF;
        checks++;
        if (done_cnt - d0 !== 2 || got_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got %0d want 2", done_cnt - d0);
        end else begin
            checks++;
            if (got_q[0] !== 8'h00 || got_q[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_data got %h %h want 00 ff", got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_baud_tol();
        int bps[2];
        bps[0] = 102; bps[1] = 106;
        foreach (bps[j]) begin
            int d0, f0;
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(8'h81, bps[j], 1'b1);
            idle(20);
            exp_rx_data = 8'h81;
            checks++;
            if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 0 || rx_data !== exp_rx_data) begin
                failures++;
                $display("FAIL tol_bp%0d got done=%0d ferr=%0d data=%h want 1 0 81",
                         bps[j], done_cnt - d0, ferr_cnt - f0, rx_data);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int d0, f0, exp_ferr;
        d0 = done_cnt; f0 = ferr_cnt; got_q.delete();
        exp_ferr = 0;
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            int bp, gap;
            logic stop;
            b    = 8'($urandom);
            bp   = 102 + int'($urandom_range(4, 0));
            stop = ($urandom_range(3, 0) != 0);
            gap  = int'($urandom_range(30, 0));
            if (!stop && gap < 4) gap = 4;
            send_frame(b, bp, stop);
            if (stop) begin
                exp_q.push_back(b);
                exp_rx_data = b;
            end else begin
                exp_ferr++;
            end
            if (gap > 0) idle(gap);
        end
        idle(20);
        checks++;
        if (done_cnt - d0 !== exp_q.size() || ferr_cnt - f0 !== exp_ferr) begin
            failures++;
            $display("FAIL rand_counts got done=%0d ferr=%0d want %0d %0d",
                     done_cnt - d0, ferr_cnt - f0, exp_q.size(), exp_ferr);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rx_data !== exp_rx_data) begin
            failures++;
            $display("FAIL rand_last got %h want %h", rx_data, exp_rx_data);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (both_cnt !== 0 || wide_cnt !== 0) begin
            failures++;
            $display("FAIL pulse_rules got overlap=%0d wide=%0d want 0 0", both_cnt, wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_back_to_back();
        test_baud_tol();
        test_random();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
